// File: rtl/datapath_seq_pkg.sv
// datapath_seq_pkg: shared types, encodings and state-to-control mapping for the datapath sequencer
package datapath_seq_pkg;
    localparam int DW = 16;
    localparam logic [2:0] OP3_MOV  = 3'b110;
    localparam logic [2:0] OP3_ALU  = 3'b101;
    localparam logic [1:0] OP2_MOVI = 2'b10;
    localparam logic [1:0] OP2_MOVR = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;
    localparam logic VSEL_C  = 1'b0;
    localparam logic VSEL_IN = 1'b1;
    typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, EXEC, WB_REG, WB_IMM} state_t;
    typedef enum logic [2:0] {CL_MOVI, CL_MOVR, CL_ALU, CL_CMP, CL_MVN, CL_ILL} cls_t;
    typedef struct packed {
        logic [1:0]    op2;
        logic [2:0]    rn;
        logic [2:0]    rd;
        logic [1:0]    sh;
        logic [2:0]    rm;
        logic [DW-1:0] sximm8;
        cls_t          cls;
    } dec_t;
    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       vsel;
        logic       asel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctl_t;
    // Moore control word for a state; MOV reg is A=0 plus B, CMP only updates status
    function automatic ctl_t ctl_of(state_t s, dec_t d);
        ctl_t c = '0;
        case (s)
            GET_A: begin
                c.readnum = d.rn;
                c.loada   = 1'b1;
            end
            GET_B: begin
                c.readnum = d.rm;
                c.loadb   = 1'b1;
            end
            EXEC: begin
                c.shift = d.sh;
                c.aluop = d.cls == CL_MOVR ? ALU_ADD : d.op2;
                c.asel  = d.cls == CL_MOVR;
                c.loadc = d.cls != CL_CMP;
                c.loads = d.cls == CL_CMP;
            end
            WB_REG: begin
                c.write    = 1'b1;
                c.vsel     = VSEL_C;
                c.writenum = d.rd;
            end
            WB_IMM: begin
                c.write    = 1'b1;
                c.vsel     = VSEL_IN;
                c.writenum = d.rn;
            end
            default: ;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/datapath_seq_instr_dec.sv
// instr_dec: field extraction, sximm8, legality and class of a 16-bit instruction
// ports: instr (in, 16) raw instruction; dec (out, dec_t) decoded fields and class
module instr_dec
    import datapath_seq_pkg::*;
(
    input  logic [15:0] instr,
    output dec_t        dec
);
    logic [2:0] op3;
    logic [1:0] op2;
    assign op3 = instr[15:13];
    assign op2 = instr[12:11];
    always_comb begin
        dec.op2    = op2;
        dec.rn     = instr[10:8];
        dec.rd     = instr[7:5];
        dec.sh     = instr[4:3];
        dec.rm     = instr[2:0];
        dec.sximm8 = {{(DW-8){instr[7]}}, instr[7:0]};
        dec.cls    = op3 == OP3_MOV && op2 == OP2_MOVI ? CL_MOVI :
                     op3 == OP3_MOV && op2 == OP2_MOVR ? CL_MOVR :
                     op3 != OP3_ALU                    ? CL_ILL  :
                     op2 == ALU_SUB                    ? CL_CMP  :
                     op2 == ALU_NOTB                   ? CL_MVN  : CL_ALU;
    end
endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: multi-cycle controller sequencing the register/ALU/shifter datapath
// ports: clk, reset (sync, active-high); start/instr request; busy, done, illegal status;
//        readnum/writenum, loada/loadb/loadc/loads, write, vsel, asel, bsel, shift, ALUop,
//        datapath_in (sximm8 of the latched instruction) datapath controls
module datapath_seq
    import datapath_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [15:0]   instr,
    output logic          busy,
    output logic          done,
    output logic          illegal,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          write,
    output logic          vsel,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [DW-1:0] datapath_in
);
    state_t        state, nxt;
    logic [15:0]   ir, nir;
    dec_t          dec;
    ctl_t          ctl;
    logic          fin;
    logic [DW-1:0] dp_in;
    // Decoding the next instruction register lets the controls be registered from the next state
    assign nir = state == WAIT && start ? instr : ir;
    instr_dec u_dec (.instr(nir), .dec(dec));
    always_comb begin
        case (state)
            WAIT:    nxt = start ? DECODE : WAIT;
            DECODE:  nxt = dec.cls == CL_MOVI ? WB_IMM :
                           dec.cls == CL_ILL  ? WAIT   :
                           dec.cls == CL_MOVR || dec.cls == CL_MVN ? GET_B : GET_A;
            GET_A:   nxt = GET_B;
            GET_B:   nxt = EXEC;
            EXEC:    nxt = dec.cls == CL_CMP ? WAIT : WB_REG;
            default: nxt = WAIT;
        endcase
        fin = state == WB_REG || state == WB_IMM ||
              (state == EXEC && dec.cls == CL_CMP) || (state == DECODE && dec.cls == CL_ILL);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WAIT;
            ir      <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            ctl     <= '0;
            dp_in   <= '0;
        end else begin
            state   <= nxt;
            ir      <= nir;
            done    <= fin;
            illegal <= state == DECODE && dec.cls == CL_ILL;
            ctl     <= ctl_of(nxt, dec);
            dp_in   <= dec.sximm8;
        end
    end
    assign busy        = state != WAIT;
    assign readnum     = ctl.readnum;
    assign writenum    = ctl.writenum;
    assign loada       = ctl.loada;
    assign loadb       = ctl.loadb;
    assign loadc       = ctl.loadc;
    assign loads       = ctl.loads;
    assign write       = ctl.write;
    assign vsel        = ctl.vsel;
    assign asel        = ctl.asel;
    assign bsel        = 1'b0;
    assign shift       = ctl.shift;
    assign ALUop       = ctl.aluop;
    assign datapath_in = dp_in;
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: scoreboard bench for datapath_seq with directed and random instructions
module tb_datapath_seq;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] instr;
    logic        busy, done, illegal, loada, loadb, loadc, loads, write, vsel, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;
    int checks = 0, errors = 0, cyc = 0;
    datapath_seq dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .busy(busy), .done(done),
        .illegal(illegal), .readnum(readnum), .writenum(writenum), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .write(write), .vsel(vsel), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {
        int lat; bit ill;
        int nla; logic [2:0] ra;
        int nlb; logic [2:0] rb;
        int nlc; int nls; int ce; logic [1:0] sh; logic [1:0] alu; bit asel;
        int nwr; logic [2:0] wn; bit vs; logic [15:0] imm;
        int t0;
    } exp_t;
    exp_t q[$];
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask
    // Expected transaction from the instruction-set rules and the latency table
    function automatic exp_t model(logic [15:0] i);
        exp_t e = '{default: 0};
        logic [2:0] op3 = i[15:13];
        logic [1:0] op2 = i[12:11];
        e.imm = {{8{i[7]}}, i[7:0]};
        e.sh  = i[4:3];
        if (op3 == 3'b110 && op2 == 2'b10) begin
            e.lat = 3; e.nwr = 1; e.wn = i[10:8]; e.vs = 1;
        end else if (op3 == 3'b110 && op2 == 2'b00) begin
            e.lat = 5; e.nlb = 1; e.rb = i[2:0]; e.nlc = 1; e.ce = 3; e.alu = 0; e.asel = 1;
            e.nwr = 1; e.wn = i[7:5];
        end else if (op3 == 3'b101) begin
            e.nlb = 1; e.rb = i[2:0]; e.alu = op2;
            if (op2 == 2'b11) begin
                e.lat = 5; e.ce = 3; e.nlc = 1; e.nwr = 1; e.wn = i[7:5];
            end else begin
                e.nla = 1; e.ra = i[10:8]; e.ce = 4;
                if (op2 == 2'b01) begin
                    e.lat = 5; e.nls = 1;
                end else begin
                    e.lat = 6; e.nlc = 1; e.nwr = 1; e.wn = i[7:5];
                end
            end
        end else begin
            e.lat = 2; e.ill = 1;
        end
        return e;
    endfunction
    int ola, olb, olc, ols, oce, onw, ocw, k;
    logic [2:0] ora, orb, own;
    logic [1:0] osh, oalu;
    logic oasel, ovs;
    logic [15:0] oimm;
    task automatic clear_obs();
        ola = 0; olb = 0; olc = 0; ols = 0; oce = -1; onw = 0; ocw = -1;
    endtask
    initial clear_obs();
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            clear_obs();
        end else if (q.size() == 0) begin
            if (done || busy || loada || loadb || loadc || loads || write)
                chk("spurious_activity", {done, busy, loada, loadb, loadc, loads, write}, 0);
        end else begin
            k = cyc - q[0].t0;
            if (loada) begin ola++; ora = readnum; end
            if (loadb) begin olb++; orb = readnum; end
            if (loadc || loads) begin
                olc += int'(loadc); ols += int'(loads); oce = k;
                osh = shift; oalu = ALUop; oasel = asel;
            end
            if (write) begin onw++; ocw = k; own = writenum; ovs = vsel; oimm = datapath_in; end
            if (done) begin
                chk("latency", k, q[0].lat);
                chk("illegal", illegal, q[0].ill);
                chk("n_loada", ola, q[0].nla);
                if (q[0].nla > 0) chk("loada_readnum", ora, q[0].ra);
                chk("n_loadb", olb, q[0].nlb);
                if (q[0].nlb > 0) chk("loadb_readnum", orb, q[0].rb);
                chk("n_loadc", olc, q[0].nlc);
                chk("n_loads", ols, q[0].nls);
                if (q[0].nlc + q[0].nls > 0) begin
                    chk("exec_cycle", oce, q[0].ce);
                    chk("shift", osh, q[0].sh);
                    chk("aluop", oalu, q[0].alu);
                    chk("asel", oasel, q[0].asel);
                end
                chk("n_write", onw, q[0].nwr);
                if (q[0].nwr > 0) begin
                    chk("write_cycle", ocw, q[0].lat - 1);
                    chk("writenum", own, q[0].wn);
                    chk("vsel", ovs, q[0].vs);
                    chk("write_datapath_in", oimm, q[0].imm);
                end
                chk("datapath_in", datapath_in, q[0].imm);
                chk("bsel", bsel, 0);
                void'(q.pop_front());
                clear_obs();
            end else if (k > 12) begin
                chk("done_timeout", k, q[0].lat);
                void'(q.pop_front());
                clear_obs();
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(logic [15:0] i);
        exp_t e;
        int n = 0;
        while (busy && n < 30) begin step(); n++; end
        if (busy) chk("idle_timeout", busy, 0);
        start = 1'b1;
        instr = i;
        @(posedge clk);
        e = model(i);
        e.t0 = cyc;
        q.push_back(e);
        #1;
        start = 1'b0;
        instr = 16'($urandom);
    endtask
    function automatic logic [15:0] rand_instr();
        logic [15:0] r = 16'($urandom);
        case ($urandom_range(0, 4))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2, 3: r[15:13] = 3'b101;
            default: ;
        endcase
        return r;
    endfunction
    initial begin
        int n;
        reset = 1'b1; start = 1'b0; instr = '0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_ctl", {loada, loadb, loadc, loads, write, vsel, asel, bsel, readnum, writenum, shift, ALUop}, 0);
        chk("rst_datapath_in", datapath_in, 0);
        reset = 1'b0;
        step();
        issue(16'hD007);
        issue(16'hD1FE);
        issue(16'hA148);
        issue(16'hA801);
        issue(16'hE000);
        issue(16'hC0AA);
        issue(16'hB8E3);
        issue(16'hB2B9);
        issue(16'hA148);
        n = 0;
        while (!loadb && n < 10) begin step(); n++; end
        chk("reach_get_b", loadb, 1);
        start = 1'b1;
        instr = 16'hD007;
        step();
        start = 1'b0;
        issue(16'hA148);
        n = 0;
        while (!loadc && n < 10) begin step(); n++; end
        chk("reach_exec", loadc, 1);
        reset = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_write", write, 0);
        chk("abort_done", done, 0);
        chk("abort_loadc", loadc, 0);
        reset = 1'b0;
        repeat (8) step();
        for (int i = 0; i < 300; i++) begin
            issue(rand_instr());
            repeat ($urandom_range(0, 2)) step();
        end
        n = 0;
        while (q.size() != 0 && n < 50) begin step(); n++; end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
